// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, master
// indices and the read-latency counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    // Wide enough for read latencies 1..7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way request arbiter.
// Build option DMEM_ARB_RR_EN: when defined, contention is resolved
// round-robin against a last-granted pointer (m0 wins first out of reset);
// when undefined, m0 always wins and m1 may starve.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_en_i,
    output logic winner_o
);

`ifdef DMEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    // On contention favour the master that did not win last time.
    always_comb begin
        winner_o = M_CPU;
        if (req0_i && req1_i) begin
            winner_o = ~last_q;
        end else if (req1_i) begin
            winner_o = M_DBG;
        end
    end

    // Pointer follows every grant, contended or not.
    always_comb begin
        last_d = last_q;
        if (grant_en_i) begin
            last_d = winner_o;
        end
    end

    // Last-granted pointer; reset to m1 so that m0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M_DBG;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: m0 first, m1 only when m0 is quiet.
    always_comb begin
        winner_o = M_CPU;
        if (!req0_i && req1_i) begin
            winner_o = M_DBG;
        end
    end

    // No pointer state is kept in this build.
    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, rst_n, grant_en_i};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU port (m0) and the
// loader/debug port (m1): one access per grant, waits out the read latency,
// then pulses a one-cycle ack with registered read data. All outputs are
// registered. Arbitration policy on contention is selected by the
// DMEM_ARB_RR_EN build option (see rr_arb2).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant
);

    localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    logic              grant_en;
    logic              winner;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (reset),
        .req0_i     (m0_req),
        .req1_i     (m1_req),
        .grant_en_i (grant_en),
        .winner_o   (winner)
    );

    // Next-state logic; strobes and acks are computed one cycle early so
    // they leave the chip straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        grant_d  = grant_q;
        grant_en = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 4'b0000;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_en = 1'b1;
                    grant_d  = winner;
                    addr_d   = (winner == M_DBG) ? m1_addr  : m0_addr;
                    wdata_d  = (winner == M_DBG) ? m1_wdata : m0_wdata;
                    we_d     = (winner == M_DBG) ? m1_we    : m0_we;
                    mem_en_d = 1'b1;
                    mem_we_d = (winner == M_DBG) ? m1_we    : m0_we;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q != 4'b0000) begin
                    ack0_d  = (grant_q == M_CPU);
                    ack1_d  = (grant_q == M_DBG);
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = RD_LAT_C;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata;
                    ack0_d  = (grant_q == M_CPU);
                    ack1_d  = (grant_q == M_DBG);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Requests are ignored here; a held req becomes a new
                // transaction in the following IDLE cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            rdata_q  <= '0;
            grant_q  <= M_CPU;
            busy_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances with RD_LAT = 1, 3, 4 driven
// independently. A transaction-level model predicts every output each cycle
// from the timing rules (issue at t+1, ack at t+2 or t+2+RD_LAT); directed
// tests add literal expectations. Honours DMEM_ARB_RR_EN for arbitration.
module tb_dmem_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n   [NI];
    logic        req0    [NI];
    logic        req1    [NI];
    logic [31:0] addr0   [NI];
    logic [31:0] addr1   [NI];
    logic [31:0] wdata0  [NI];
    logic [31:0] wdata1  [NI];
    logic [3:0]  we0     [NI];
    logic [3:0]  we1     [NI];
    logic [31:0] mem_rd  [NI];
    logic        ack0_o  [NI];
    logic        ack1_o  [NI];
    logic [31:0] rd0_o   [NI];
    logic [31:0] rd1_o   [NI];
    logic        men_o   [NI];
    logic [31:0] maddr_o [NI];
    logic [31:0] mwd_o   [NI];
    logic [3:0]  mwe_o   [NI];
    logic        busy_o  [NI];
    logic        grant_o [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_arbiter #(.RD_LAT(gi == 0 ? 1 : (gi == 1 ? 3 : 4))) u_dut (
            .clk       (clk),
            .reset     (rst_n[gi]),
            .m0_req    (req0[gi]),
            .m0_addr   (addr0[gi]),
            .m0_wdata  (wdata0[gi]),
            .m0_we     (we0[gi]),
            .m0_ack    (ack0_o[gi]),
            .m0_rdata  (rd0_o[gi]),
            .m1_req    (req1[gi]),
            .m1_addr   (addr1[gi]),
            .m1_wdata  (wdata1[gi]),
            .m1_we     (we1[gi]),
            .m1_ack    (ack1_o[gi]),
            .m1_rdata  (rd1_o[gi]),
            .mem_en    (men_o[gi]),
            .mem_addr  (maddr_o[gi]),
            .mem_wdata (mwd_o[gi]),
            .mem_we    (mwe_o[gi]),
            .mem_rdata (mem_rd[gi]),
            .busy      (busy_o[gi]),
            .grant     (grant_o[gi])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0008: return 32'hCAFE_0008;
            default:       return a ^ 32'h5A5A_A5A5;
        endcase
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) $display("FAIL %s inst%0d cyc%0d got %h want %h", nm, i, cyc, a, e);
        else         n_pass++;
    endtask

    // ---------------- transaction-level model ----------------
    bit          act       [NI];
    int          t0        [NI];
    int          mst       [NI];
    bit          wr        [NI];
    logic [3:0]  cap_we    [NI];
    logic [31:0] cap_addr  [NI];
    logic [31:0] cap_wdata [NI];
    logic [31:0] ma        [NI];
    logic [31:0] mwd       [NI];
    logic [31:0] rdm       [NI];
    int          gprev     [NI];
    int          last      [NI];
    int          ackcnt    [NI][2];
    int          lat_rec   [NI];
    logic [31:0] ackrd_rec [NI];
    int          gseq      [NI][$];

    task automatic model_reset(input int i);
        act[i] = 1'b0; ma[i] = '0; mwd[i] = '0; rdm[i] = '0;
        gprev[i] = 0; last[i] = 1;
    endtask

    function automatic int ack_cycle(input int i);
        return t0[i] + (wr[i] ? 2 : 2 + lat_of(i));
    endfunction

    task automatic compare(input int i);
        bit busy_e, en_e, a0_e, a1_e;
        int g_e;
        if (act[i] && cyc == t0[i] + 1) begin
            ma[i]  = cap_addr[i];
            mwd[i] = cap_wdata[i];
        end
        busy_e = act[i] && (cyc > t0[i]);
        en_e   = act[i] && (cyc == t0[i] + 1);
        a0_e   = act[i] && (cyc == ack_cycle(i)) && (mst[i] == 0);
        a1_e   = act[i] && (cyc == ack_cycle(i)) && (mst[i] == 1);
        g_e    = busy_e ? mst[i] : gprev[i];
        chk("busy",   i, 32'(busy_o[i]),  32'(busy_e));
        chk("mem_en", i, 32'(men_o[i]),   32'(en_e));
        chk("mem_we", i, 32'(mwe_o[i]),   en_e ? 32'(cap_we[i]) : 32'd0);
        chk("m0_ack", i, 32'(ack0_o[i]),  32'(a0_e));
        chk("m1_ack", i, 32'(ack1_o[i]),  32'(a1_e));
        chk("grant",  i, 32'(grant_o[i]), 32'(g_e));
        chk("m_addr", i, maddr_o[i], ma[i]);
        chk("m_wdat", i, mwd_o[i],   mwd[i]);
        chk("rdata0", i, rd0_o[i],   rdm[i]);
        chk("rdata1", i, rd1_o[i],   rdm[i]);
    endtask

    task automatic step(input int i);
        int w;
        if (act[i] && !wr[i] && cyc == t0[i] + 1 + lat_of(i)) rdm[i] = mem_rd[i];
        if (act[i] && cyc == ack_cycle(i)) begin
            act[i] = 1'b0;
            gprev[i] = mst[i];
            ackcnt[i][mst[i]]++;
            lat_rec[i] = cyc - t0[i];
            ackrd_rec[i] = (mst[i] == 1) ? rd1_o[i] : rd0_o[i];
        end else if (!act[i] && (req0[i] || req1[i])) begin
`ifdef DMEM_ARB_RR_EN
            if (req0[i] && req1[i]) w = 1 - last[i];
            else                    w = req1[i] ? 1 : 0;
            last[i] = w;
`else
            w = req0[i] ? 0 : 1;
`endif
            act[i] = 1'b1;
            t0[i]  = cyc;
            mst[i] = w;
            cap_we[i]    = (w == 1) ? we1[i]    : we0[i];
            cap_addr[i]  = (w == 1) ? addr1[i]  : addr0[i];
            cap_wdata[i] = (w == 1) ? wdata1[i] : wdata0[i];
            wr[i] = (cap_we[i] != 4'b0000);
            gseq[i].push_back(w);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) model_reset(i);
            compare(i);
            if (rst_n[i]) step(i);
        end
    end

    // Memory: valid word only in the sampling cycle, garbage otherwise.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (act[i] && !wr[i] && cyc == t0[i] + 1 + lat_of(i)) mem_rd[i] = mem_word(cap_addr[i]);
            else                                                 mem_rd[i] = $urandom;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int i, input int m, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] we);
        int target;
        target = ackcnt[i][m] + 1;
        if (m == 0) begin req0[i] = 1'b1; addr0[i] = a; wdata0[i] = d; we0[i] = we; end
        else        begin req1[i] = 1'b1; addr1[i] = a; wdata1[i] = d; we1[i] = we; end
        for (int k = 0; k < 40 && ackcnt[i][m] < target; k++) tick();
        if (ackcnt[i][m] < target) begin
            n_checks++;
            $display("FAIL txn_timeout inst%0d got no ack want ack", i);
        end
        if (m == 0) req0[i] = 1'b0;
        else        req1[i] = 1'b0;
        tick();
    endtask

    int exp_g[4];
    int base;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; req0[i] = 1'b0; req1[i] = 1'b0;
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
            we0[i] = '0; we1[i] = '0;
            model_reset(i);
            ackcnt[i][0] = 0; ackcnt[i][1] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        tick();

        // m0 read, RD_LAT=1
        txn(0, 0, 32'h100, 32'h0, 4'b0000);
        chk("rd1_lat",   0, 32'(lat_rec[0]), 32'd3);
        chk("rd1_rdata", 0, ackrd_rec[0], 32'hDEAD_BEEF);

        // m1 write: rdata register must keep the earlier read value
        txn(0, 1, 32'h40, 32'h1234_5678, 4'b0011);
        chk("wr_lat",   0, 32'(lat_rec[0]), 32'd2);
        chk("wr_rdata", 0, ackrd_rec[0], 32'hDEAD_BEEF);

        // contention: both hold read requests for four transactions
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        gseq[0].delete();
        base = ackcnt[0][0] + ackcnt[0][1];
        req0[0] = 1'b1; addr0[0] = 32'h10; we0[0] = 4'b0000;
        req1[0] = 1'b1; addr1[0] = 32'h20; we1[0] = 4'b0000;
        for (int k = 0; k < 100 && ackcnt[0][0] + ackcnt[0][1] < base + 4; k++) tick();
        req0[0] = 1'b0; req1[0] = 1'b0;
        tick();
        chk("cont_len", 0, 32'(gseq[0].size()), 32'd4);
        for (int k = 0; k < 4 && k < gseq[0].size(); k++) chk("cont_grant", 0, 32'(gseq[0][k]), 32'(exp_g[k]));
`ifndef DMEM_ARB_RR_EN
        chk("cont_m1_acks", 0, 32'(ackcnt[0][1]), 32'd1);
`endif

        // RD_LAT=4 reads on both ports with garbage around the valid cycle
        txn(2, 0, 32'h200, 32'h0, 4'b0000);
        chk("rd4_lat",   2, 32'(lat_rec[2]), 32'd6);
        chk("rd4_rdata", 2, ackrd_rec[2], 32'h5A5A_A7A5);
        txn(2, 1, 32'h300, 32'h0, 4'b0000);
        chk("rd4m1_lat",   2, 32'(lat_rec[2]), 32'd6);
        chk("rd4m1_rdata", 2, ackrd_rec[2], 32'h5A5A_A6A5);

        // reset during WAIT, RD_LAT=3
        req0[1] = 1'b1; addr0[1] = 32'h4; we0[1] = 4'b0000;
        for (int k = 0; k < 20 && !(act[1] && cyc == t0[1] + 3); k++) tick();
        if (!(act[1] && cyc == t0[1] + 3)) begin
            n_checks++;
            $display("FAIL rst_setup inst1 got no WAIT cycle want WAIT cycle");
        end
        rst_n[1] = 1'b0;
        req0[1] = 1'b0;
        #1;
        chk("rst_busy",  1, 32'(busy_o[1]),  32'd0);
        chk("rst_maddr", 1, maddr_o[1],      32'd0);
        chk("rst_ack0",  1, 32'(ack0_o[1]),  32'd0);
        chk("rst_grant", 1, 32'(grant_o[1]), 32'd0);
        tick();
        tick();
        rst_n[1] = 1'b1;
        tick();
        txn(1, 0, 32'h8, 32'h0, 4'b0000);
        chk("rst_rd_lat",   1, 32'(lat_rec[1]), 32'd5);
        chk("rst_rd_rdata", 1, ackrd_rec[1], 32'hCAFE_0008);
        chk("rst_acks",     1, 32'(ackcnt[1][0]), 32'd1);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer that shares the single-ported data memory between the CPU data port (master 0) and a loader/debug port (master 1). It grants one master at a time, issues exactly one memory access per grant, waits out the memory read latency, and returns a one-cycle acknowledge with registered read data. The CPU stalls on its port until the acknowledge arrives.

## Interface
- `RD_LAT`, default 1: cycles from the issue cycle until `mem_rdata` is valid; legal range 1..7.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m0_req` in 1: CPU request, held until `m0_ack`.
- `m0_addr` in 32; `m0_wdata` in 32; `m0_we` in 4: byte write enables, nonzero = write, zero = read.
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_rdata` out 32: read data, valid with `m0_ack` on reads.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_ack`, `m1_rdata`: same as m0, for the loader/debug port.
- `mem_en` out 1: access strobe, high for exactly the issue cycle.
- `mem_addr` out 32; `mem_wdata` out 32; `mem_we` out 4: access to memory.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: arbiter is not IDLE.
- `grant` out 1: index of the owning master; meaningful while `busy`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any `mX_req`, select the winner and capture its addr/wdata/we into registers. Set `grant`, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `mem_en`=1 and `mem_we`=captured we. On a write, go to ACK. On a read, load the latency counter with `RD_LAT` and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter equals 1, capture `mem_rdata` into the rdata register and go to ACK.
- ACK: pulse `ack` of the granted master for one cycle, then go to IDLE unconditionally. Requests are ignored in ACK.
- Requester protocol: hold `req` and payload stable until `ack`. A `req` still high in the cycle after `ack` is a new transaction.
- If `req` drops before `ack`, the transaction still completes and `ack` is still pulsed.
- `mem_we` is 0 and `mem_en` is 0 outside ISSUE.
- `mem_addr`/`mem_wdata` hold their captured values until the next capture.
- `m0_rdata` and `m1_rdata` are both driven from the single rdata register. The register is updated only on read captures, so it holds its value across writes.
- Arbitration when both masters request in IDLE: see Configuration. A single requester always wins.
- Reset values (async, on `reset`=0): state IDLE, counter 0, all acks 0, `mem_en` 0, `mem_we` 0, `mem_addr`/`mem_wdata`/rdata 0, `busy` 0, `grant` 0, RR pointer = last-granted 1.
- Reset mid-transaction: the in-flight access is dropped and no ack is issued.

## Timing
- Let `req` be first seen in IDLE in cycle t. ISSUE is in cycle t+1.
- Write: `ack` in cycle t+2.
- Read: WAIT occupies cycles t+2..t+1+RD_LAT, with `mem_rdata` sampled at the end of cycle t+1+RD_LAT. `ack` is in cycle t+2+RD_LAT.
- Back-to-back: ACK is always followed by at least one IDLE cycle. Minimum spacing is 3 cycles for writes and RD_LAT+3 for reads.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On contention, grant the master that was not last granted.
  - The pointer updates at each grant.
  - Out of reset, m0 wins first.
- `DMEM_ARB_RR_EN` undefined: fixed priority, m0 always wins on contention. m1 can starve; this is intended.

## Structure
- Shared package `dmem_arb_pkg`:
  - FSM state enum.
  - Master index constants `M_CPU`=0, `M_DBG`=1.
  - Latency counter width constant (3 bits).
- One sub-module, `rr_arb2`: a 2-way arbiter holding the last-granted pointer.
  - Inputs: two reqs and a grant-enable. Outputs: winner index.
  - Its fixed-priority/RR selection is controlled by the macro.

## Test plan
- Read, RD_LAT=1: m0 reads 0x100, memory returns 0xDEADBEEF. Expect `mem_en` high one cycle (t+1), `m0_ack` at t+3 with `m0_rdata`=0xDEADBEEF, and `m1_ack` stays 0.
- Write: m1 writes 0x12345678 to 0x40 with we=4'b0011. Expect `mem_we`=0011 only in cycle t+1, `m1_ack` at t+2, and rdata register unchanged.
- Contention: both masters hold read `req` for four transactions.
  - With `DMEM_ARB_RR_EN`: `grant` sequence is 0,1,0,1.
  - Without it: 0,0,0,0 and `m1_ack` never pulses.
- Reset mid-op, RD_LAT=3: assert `reset`=0 during WAIT. Expect all outputs to go to zero asynchronously and no ack. After release, an m0 read of 0x8 is acked at t+5.
- RD_LAT=4 read, with `mem_rdata` toggling garbage except at the valid cycle t+5. Expect `ack` at t+6 with the valid-cycle value.
